// File: rtl/mont_mul_serial_if.sv
// Operand/result bundle between the ECC point-arithmetic controller and the
// Montgomery multiplier, sharing the in_sig/done handshake of the domain-transfer block.
interface mont_mul_serial_if #(
  parameter int WIDTH = 32
);
  logic             in_sig;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic [WIDTH-1:0] Prime;
  logic [WIDTH-1:0] R_out;
  logic             done;
  logic             busy;

  modport master (
    output in_sig, A_i, B_i, Prime,
    input  R_out, done, busy
  );

  modport slave (
    input  in_sig, A_i, B_i, Prime,
    output R_out, done, busy
  );
endinterface

// File: rtl/mont_mul_serial.sv
// Bit-serial radix-2 Montgomery multiplier: R_out = A*B*2^-WIDTH mod Prime,
// one multiplicand bit per clock, operands and result in the Montgomery domain.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for in_sig; latches reduced operands and Prime
// ST_CALC  | one Montgomery iteration per cycle, WIDTH cycles total
// ST_FINAL | conditional subtract of T into R_out
// ST_OUT   | done pulse, then back to idle
module mont_mul_serial #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  mont_mul_serial_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FINAL = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] aq;
  logic [WIDTH-1:0] bq;
  logic [WIDTH-1:0] prime_q;
  logic [WIDTH-1:0] r_out_q;
  logic             done_q;

  logic [WIDTH-1:0] a_red;
  logic [WIDTH-1:0] b_red;
  logic [WIDTH+1:0] t1;
  logic [WIDTH:0]   t_nxt;
  logic [WIDTH:0]   p_half_up;
  logic             t_ge_p;
  logic [WIDTH-1:0] r_nxt;

  always_comb begin
    a_red = (bus.A_i >= bus.Prime) ? bus.A_i - bus.Prime : bus.A_i;
    b_red = (bus.B_i >= bus.Prime) ? bus.B_i - bus.Prime : bus.B_i;

    t1 = {1'b0, t} + (aq[cnt] ? {2'b00, bq} : '0);

    // (t1 + P) / 2 with both odd equals (t1 >> 1) + (P >> 1) + 1; the result
    // stays below 2*P, so WIDTH+1 bits hold it without loss.
    p_half_up = {2'b00, prime_q[WIDTH-1:1]} + (WIDTH+1)'(1);
    t_nxt     = t1[WIDTH+1:1] + (t1[0] ? p_half_up : '0);

    // T < 2*P, so when T >= P the difference fits in WIDTH bits.
    t_ge_p = (t >= {1'b0, prime_q});
    r_nxt  = t_ge_p ? (t[WIDTH-1:0] - prime_q) : t[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.in_sig) state_nxt = ST_CALC;
      ST_CALC:  if (cnt == CNT_W'(WIDTH-1)) state_nxt = ST_FINAL;
      ST_FINAL: state_nxt = ST_OUT;
      ST_OUT:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      t       <= '0;
      aq      <= '0;
      bq      <= '0;
      prime_q <= '0;
      r_out_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == ST_FINAL);
      case (state)
        ST_IDLE: begin
          if (bus.in_sig) begin
            aq      <= a_red;
            bq      <= b_red;
            prime_q <= bus.Prime;
            t       <= '0;
            cnt     <= '0;
          end
        end
        ST_CALC: begin
          t   <= t_nxt;
          cnt <= cnt + CNT_W'(1);
        end
        ST_FINAL: r_out_q <= r_nxt;
        default: ;
      endcase
    end
  end

  assign bus.R_out = r_out_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state != ST_IDLE);

endmodule
